// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: pipeline, IO and data-memory signals of the dmem port arbiter
`timescale 1ns/1ps
interface dmem_port_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          stall;
    logic [DW-1:0] rdata;
    logic          io_req;
    logic          io_we;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_wdata;
    logic          io_gnt;
    logic          io_ack;
    logic [DW-1:0] io_rdata;
    logic          dmem_en;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    modport slave (
        input  mem_read, mem_write, addr, wdata, io_req, io_we, io_addr, io_wdata, dmem_rdata,
        output stall, rdata, io_gnt, io_ack, io_rdata, dmem_en, dmem_we, dmem_addr, dmem_wdata
    );
    modport master (
        output mem_read, mem_write, addr, wdata, io_req, io_we, io_addr, io_wdata, dmem_rdata,
        input  stall, rdata, io_gnt, io_ack, io_rdata, dmem_en, dmem_we, dmem_addr, dmem_wdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port data memory between the MEM stage and the IO port; DMEM_ARB_RR_EN selects round-robin instead of fixed PIPE priority
`timescale 1ns/1ps
module dmem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_STATES = 2
) (
    input logic             clk,
    input logic             rst_n,
    dmem_port_arbiter_if.slave bus
);
    localparam int CW = WAIT_STATES > 1 ? $clog2(WAIT_STATES) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t        state, state_nx;
    logic          owner_io;
    logic [CW-1:0] cnt;
    logic          dmem_en, dmem_we, io_ack;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata, rdata, io_rdata;
    logic          pipe_req, launch, pick_io, done;
    assign pipe_req = bus.mem_read | bus.mem_write;
`ifdef DMEM_ARB_RR_EN
    logic last_io;
    assign pick_io = bus.io_req & (~pipe_req | ~last_io);
    // remember who won the last grant so a conflict goes to the other side
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_io <= 1'b1;
        else if (launch) last_io <= pick_io;
`else
    assign pick_io = bus.io_req & ~pipe_req;
`endif
    // next-state: launch from IDLE, leave BUSY when the wait count expires, RESP lasts one cycle
    always_comb begin
        launch   = (state == IDLE) & (pipe_req | bus.io_req);
        done     = (state == BUSY) & (cnt == '0);
        state_nx = launch ? BUSY : done ? RESP : (state == RESP) ? IDLE : state;
    end
    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    // latch the winning request, count wait states and capture read data for its owner
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            owner_io   <= 1'b0;
            cnt        <= '0;
            dmem_en    <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            rdata      <= '0;
            io_rdata   <= '0;
            io_ack     <= 1'b0;
        end else begin
            if (launch) begin
                owner_io   <= pick_io;
                cnt        <= CW'(WAIT_STATES - 1);
                dmem_en    <= 1'b1;
                dmem_we    <= pick_io ? bus.io_we : bus.mem_write;
                dmem_addr  <= pick_io ? bus.io_addr : bus.addr;
                dmem_wdata <= pick_io ? bus.io_wdata : bus.wdata;
            end else if (state == BUSY) cnt <= cnt - CW'(1);
            if (done) begin
                dmem_en <= 1'b0;
                dmem_we <= 1'b0;
            end
            if (done & ~dmem_we & owner_io) io_rdata <= bus.dmem_rdata;
            if (done & ~dmem_we & ~owner_io) rdata <= bus.dmem_rdata;
            io_ack <= done & owner_io;
        end
    assign bus.stall      = pipe_req & ~((state == RESP) & ~owner_io);
    assign bus.io_gnt     = launch & pick_io;
    assign bus.io_ack     = io_ack;
    assign bus.rdata      = rdata;
    assign bus.io_rdata   = io_rdata;
    assign bus.dmem_en    = dmem_en;
    assign bus.dmem_we    = dmem_we;
    assign bus.dmem_addr  = dmem_addr;
    assign bus.dmem_wdata = dmem_wdata;
endmodule
